// File: rtl/voting_ballot_console.sv
// Voter-side front end for the three-candidate vote counter: button debounce,
// one-ballot-per-authorization sequencing and clean candidate pulses.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | lines low, waiting for voter_auth; presses are rejected
//  S_ARMED  | o_ready high, waiting for a single clean candidate press
//  S_SEND   | latched candidate line high for PULSE_CYCLES cycles
//  S_GAP    | lines low for >= GAP_CYCLES and until all buttons released
//  S_CLOSED | o_voting_over high until close_poll drops
module voting_ballot_console #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_1,
    input  logic        btn_2,
    input  logic        btn_3,
    input  logic        voter_auth,
    input  logic        close_poll,
    output logic        o_candidate_1,
    output logic        o_candidate_2,
    output logic        o_candidate_3,
    output logic        o_voting_over,
    output logic        o_ready,
    output logic        o_reject,
    output logic [15:0] o_ballots_cast
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] PULSE_LOAD = TM_W'(PULSE_CYCLES - 1);
    localparam logic [TM_W-1:0] GAP_LOAD   = TM_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SEND,
        S_GAP,
        S_CLOSED
    } state_t;

    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_d;
    logic [DB_W-1:0] r_db_cnt [3];

    logic [2:0]      w_press;
    logic            w_press_any;
    logic            w_press_valid;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TM_W-1:0] r_timer;
    logic [TM_W-1:0] w_timer_nxt;
    logic [2:0]      r_choice;
    logic [2:0]      w_choice_nxt;
    logic            r_close_pend;
    logic            w_close_pend_nxt;
    logic            w_reject_nxt;
    logic            w_ballot_inc;

    logic [2:0]      r_cand;
    logic            r_voting_over;
    logic            r_ready;
    logic            r_reject;
    logic [15:0]     r_ballots;

    assign w_btn_raw = {btn_3, btn_2, btn_1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Counter tracks consecutive samples that disagree with the debounced level;
    // any agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db   <= 3'b000;
            r_db_d <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press       = r_db & ~r_db_d;
    assign w_press_any   = |w_press;
    assign w_press_valid = $onehot(w_press) && ((r_db & ~w_press) == 3'b000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_choice     <= 3'b000;
            r_close_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_choice     <= w_choice_nxt;
            r_close_pend <= w_close_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_choice_nxt     = r_choice;
        w_close_pend_nxt = r_close_pend;
        w_reject_nxt     = 1'b0;
        w_ballot_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_choice_nxt     = 3'b000;
                w_close_pend_nxt = 1'b0;
                if (close_poll) begin
                    w_state_nxt = S_CLOSED;
                end else if (w_press_any) begin
                    w_reject_nxt = 1'b1;
                end else if (voter_auth) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (close_poll) begin
                    w_state_nxt = S_CLOSED;
                end else if (w_press_any) begin
                    if (w_press_valid) begin
                        w_choice_nxt = w_press;
                        w_timer_nxt  = PULSE_LOAD;
                        w_state_nxt  = S_SEND;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (close_poll) begin
                    w_close_pend_nxt = 1'b1;
                end
                if (r_timer == '0) begin
                    w_timer_nxt  = GAP_LOAD;
                    w_ballot_inc = 1'b1;
                    w_state_nxt  = S_GAP;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (close_poll) begin
                    w_close_pend_nxt = 1'b1;
                end
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (r_db == 3'b000) begin
                    // A close request seen anywhere in SEND/GAP takes effect only here.
                    w_state_nxt      = (r_close_pend || close_poll) ? S_CLOSED : S_IDLE;
                    w_close_pend_nxt = 1'b0;
                    w_choice_nxt     = 3'b000;
                end
            end
            S_CLOSED: begin
                if (!close_poll) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand        <= 3'b000;
            r_voting_over <= 1'b0;
            r_ready       <= 1'b0;
            r_reject      <= 1'b0;
        end else begin
            r_cand        <= (w_state_nxt == S_SEND) ? w_choice_nxt : 3'b000;
            r_voting_over <= (w_state_nxt == S_CLOSED);
            r_ready       <= (w_state_nxt == S_ARMED);
            r_reject      <= w_reject_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ballots <= 16'h0000;
        end else if (w_ballot_inc && (r_ballots != 16'hFFFF)) begin
            r_ballots <= r_ballots + 16'h0001;
        end
    end

    assign o_candidate_1  = r_cand[0];
    assign o_candidate_2  = r_cand[1];
    assign o_candidate_3  = r_cand[2];
    assign o_voting_over  = r_voting_over;
    assign o_ready        = r_ready;
    assign o_reject       = r_reject;
    assign o_ballots_cast = r_ballots;

endmodule

// File: tb/tb_voting_ballot_console.sv
// Self-checking bench for voting_ballot_console: a vector table for the basic
// sequencing plus directed sequences for bounce, rejects, gap, close and reset.
module tb_voting_ballot_console;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  btn;
    logic        auth;
    logic        close;
    logic [2:0]  cand;
    logic        vover;
    logic        ready;
    logic        reject;
    logic [15:0] ballots;

    logic        f_rst;
    logic [2:0]  f_btn;
    logic        f_auth;
    logic        f_close;
    logic [2:0]  f_cand;
    logic        f_vover;
    logic        f_ready;
    logic        f_reject;
    logic [15:0] f_ballots;

    voting_ballot_console u_dut (
        .clk            (clk),
        .rst            (rst),
        .btn_1          (btn[0]),
        .btn_2          (btn[1]),
        .btn_3          (btn[2]),
        .voter_auth     (auth),
        .close_poll     (close),
        .o_candidate_1  (cand[0]),
        .o_candidate_2  (cand[1]),
        .o_candidate_3  (cand[2]),
        .o_voting_over  (vover),
        .o_ready        (ready),
        .o_reject       (reject),
        .o_ballots_cast (ballots)
    );

    voting_ballot_console #(
        .DEBOUNCE_CYCLES (2),
        .PULSE_CYCLES    (4),
        .GAP_CYCLES      (18)
    ) u_fast (
        .clk            (clk),
        .rst            (f_rst),
        .btn_1          (f_btn[0]),
        .btn_2          (f_btn[1]),
        .btn_3          (f_btn[2]),
        .voter_auth     (f_auth),
        .close_poll     (f_close),
        .o_candidate_1  (f_cand[0]),
        .o_candidate_2  (f_cand[1]),
        .o_candidate_3  (f_cand[2]),
        .o_voting_over  (f_vover),
        .o_ready        (f_ready),
        .o_reject       (f_reject),
        .o_ballots_cast (f_ballots)
    );

    int tests = 0;
    int fails = 0;

    int pulses   [3] = '{0, 0, 0};
    int last_len [3] = '{0, 0, 0};
    int cur_len  [3] = '{0, 0, 0};
    int rej_hi       = 0;
    bit multi_hot    = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cand[i]) begin
                cur_len[i] <= cur_len[i] + 1;
            end else if (cur_len[i] != 0) begin
                pulses[i]   <= pulses[i] + 1;
                last_len[i] <= cur_len[i];
                cur_len[i]  <= 0;
            end
        end
        if (reject) rej_hi <= rej_hi + 1;
        if ($countones(cand) > 1 || $countones(f_cand) > 1) multi_hot <= 1'b1;
    end

    typedef struct {
        logic [2:0]  btn;
        logic        auth;
        logic        close;
        int          cyc;
        logic [2:0]  cand;
        logic        vover;
        logic        ready;
        logic        reject;
        logic [15:0] ballots;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        btn   = 3'b000;
        auth  = 1'b0;
        close = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic arm_main();
        auth = 1'b1;
        tick(1);
        auth = 1'b0;
    endtask

    task automatic vote_fast(input int idx, input logic [15:0] exp_count);
        f_auth = 1'b1;
        for (int k = 0; k < 60 && !f_ready; k++) tick(1);
        check("sat.ready", f_ready, 1);
        f_auth = 1'b0;
        f_btn[idx] = 1'b1;
        for (int k = 0; k < 20 && !f_cand[idx]; k++) tick(1);
        check("sat.pulse", f_cand[idx], 1);
        f_btn[idx] = 1'b0;
        for (int k = 0; k < 20 && f_cand[idx]; k++) tick(1);
        check("sat.pulse_end", f_cand[idx], 0);
        check("sat.count", f_ballots, exp_count);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        int rb;
        int pb0;
        int pb1;

        //            btn     au    cl   cyc  cand    vo    rdy   rej   ballots
        vecs[0]  = '{3'b000, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{3'b000, 1'b0, 1'b1,  1, 3'b000, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{3'b000, 1'b1, 1'b1,  1, 3'b000, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{3'b000, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{3'b000, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{3'b000, 1'b0, 1'b1,  1, 3'b000, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{3'b000, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{3'b000, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[8]  = '{3'b010, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[9]  = '{3'b010, 1'b0, 1'b0, 17, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[10] = '{3'b010, 1'b0, 1'b0,  1, 3'b010, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[11] = '{3'b010, 1'b0, 1'b0,  3, 3'b010, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[12] = '{3'b010, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[13] = '{3'b010, 1'b0, 1'b0,  7, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[14] = '{3'b000, 1'b1, 1'b0, 18, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[15] = '{3'b000, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[16] = '{3'b000, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[17] = '{3'b000, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd1};

        rst     = 1'b0;
        btn     = 3'b000;
        auth    = 1'b0;
        close   = 1'b0;
        f_rst   = 1'b0;
        f_btn   = 3'b000;
        f_auth  = 1'b0;
        f_close = 1'b0;
        tick(3);
        check("reset.cand",    cand,    0);
        check("reset.vover",   vover,   0);
        check("reset.ready",   ready,   0);
        check("reset.reject",  reject,  0);
        check("reset.ballots", ballots, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            btn   = vecs[i].btn;
            auth  = vecs[i].auth;
            close = vecs[i].close;
            tick(vecs[i].cyc);
            check($sformatf("vec%0d.cand", i),    cand,    vecs[i].cand);
            check($sformatf("vec%0d.vover", i),   vover,   vecs[i].vover);
            check($sformatf("vec%0d.ready", i),   ready,   vecs[i].ready);
            check($sformatf("vec%0d.reject", i),  reject,  vecs[i].reject);
            check($sformatf("vec%0d.ballots", i), ballots, vecs[i].ballots);
        end
        auth = 1'b0;
        tick(4);
        check("vec.pulse_len", last_len[1], 4);

        // bounce: toggles every 3 cycles never settle; only the final rise counts
        do_reset();
        pb0 = pulses[0];
        arm_main();
        check("bounce.armed", ready, 1);
        for (int k = 0; k < 14; k++) begin
            btn[0] = (k % 2 == 0);
            tick(3);
        end
        check("bounce.no_early", cand, 0);
        btn[0] = 1'b1;
        tick(18);
        check("bounce.t18", cand[0], 0);
        tick(1);
        check("bounce.t19", cand[0], 1);
        tick(3);
        check("bounce.t22", cand[0], 1);
        tick(1);
        check("bounce.t23", cand[0], 0);
        btn[0] = 1'b0;
        tick(5);
        check("bounce.pulses", pulses[0] - pb0, 1);
        check("bounce.len", last_len[0], 4);

        // rejects: press in IDLE, double press, press while another held
        do_reset();
        rb  = rej_hi;
        pb0 = pulses[0] + pulses[1] + pulses[2];
        btn[2] = 1'b1;
        tick(19);
        check("idle_press.reject", reject, 1);
        tick(1);
        check("idle_press.one_cycle", reject, 0);
        btn[2] = 1'b0;
        tick(20);
        check("idle_press.idle", ready, 0);
        arm_main();
        check("double.armed", ready, 1);
        btn = 3'b011;
        tick(19);
        check("double.reject", reject, 1);
        tick(3);
        check("double.still_armed", ready, 1);
        btn[1] = 1'b0;
        tick(20);
        btn[1] = 1'b1;
        tick(19);
        check("held.reject", reject, 1);
        tick(3);
        btn = 3'b000;
        tick(20);
        check("reject.count", rej_hi - rb, 3);
        check("reject.no_pulse", pulses[0] + pulses[1] + pulses[2] - pb0, 0);
        check("reject.ballots", ballots, 0);
        check("reject.armed", ready, 1);

        // held button keeps GAP alive; authorization during GAP ignored
        do_reset();
        pb0 = pulses[0];
        arm_main();
        btn[0] = 1'b1;
        tick(19);
        check("gap.pulse", cand[0], 1);
        tick(11);
        auth = 1'b1;
        tick(1);
        check("gap.auth_ignored", ready, 0);
        auth = 1'b0;
        tick(69);
        check("gap.held", ready, 0);
        btn[0] = 1'b0;
        auth   = 1'b1;
        tick(19);
        check("gap.held_wait", ready, 0);
        tick(1);
        check("gap.rearm", ready, 1);
        auth = 1'b0;
        tick(2);
        check("gap.ballots", ballots, 1);
        check("gap.pulses", pulses[0] - pb0, 1);

        // close_poll during SEND completes pulse and gap first
        do_reset();
        pb1 = pulses[1];
        arm_main();
        btn[1] = 1'b1;
        tick(19);
        check("close.pulse_start", cand[1], 1);
        tick(1);
        close = 1'b1;
        tick(2);
        check("close.pulse_full", cand[1], 1);
        tick(1);
        check("close.pulse_end", cand[1], 0);
        check("close.vover_early", vover, 0);
        tick(1);
        btn[1] = 1'b0;
        tick(22);
        check("close.gap_hold", vover, 0);
        tick(1);
        check("close.vover", vover, 1);
        tick(3);
        check("close.vover_held", vover, 1);
        close = 1'b0;
        tick(1);
        check("close.reopen", vover, 0);
        check("close.ballots", ballots, 1);
        check("close.len", last_len[1], 4);
        check("close.pulses", pulses[1] - pb1, 1);

        // saturation and async reset on the fast build
        f_rst = 1'b1;
        tick(2);
        force u_fast.r_ballots = 16'hFFFE;
        #1;
        release u_fast.r_ballots;
        #1;
        check("sat.preload", f_ballots, 16'hFFFE);
        vote_fast(0, 16'hFFFF);
        vote_fast(1, 16'hFFFF);
        vote_fast(2, 16'hFFFF);

        f_auth = 1'b1;
        for (int k = 0; k < 60 && !f_ready; k++) tick(1);
        check("rst.ready", f_ready, 1);
        f_auth = 1'b0;
        f_btn[0] = 1'b1;
        for (int k = 0; k < 20 && !f_cand[0]; k++) tick(1);
        tick(1);
        check("rst.mid_send", f_cand[0], 1);
        #2;
        f_rst = 1'b0;
        #1;
        check("rst.cand",    f_cand,    0);
        check("rst.vover",   f_vover,   0);
        check("rst.ready",   f_ready,   0);
        check("rst.reject",  f_reject,  0);
        check("rst.ballots", f_ballots, 0);
        f_btn = 3'b000;
        tick(2);

        check("one_hot", multi_hot, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
